// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: default sizes and the
// classifier's control state encoding.
package snn_pkg;

    localparam int unsigned DefNumOutputs = 100;
    localparam int unsigned DefCountWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StScan  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Per-neuron spike counter: synchronous clear, increment that sticks at all-ones.
module sat_counter
    import snn_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = DefCountWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   inc_i,
    output logic [COUNT_WIDTH-1:0] count_o
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CountMax)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Accumulates output-neuron spikes over a fixed window, then scans the counts
// one neuron per cycle to report the argmax as the classification result.
module spike_count_classifier
    import snn_pkg::*;
#(
    parameter int unsigned NUM_OUTPUTS = DefNumOutputs,
    parameter int unsigned COUNT_WIDTH = DefCountWidth,
    parameter int unsigned WINDOW      = 250,
    parameter int unsigned IDX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   spike_valid,
    input  logic [NUM_OUTPUTS-1:0] spike_in,
    output logic                   busy,
    output logic                   result_valid,
    output logic [IDX_WIDTH-1:0]   winner_idx,
    output logic [COUNT_WIDTH-1:0] winner_count,
    output logic                   no_spikes
);

    localparam int unsigned TsWidth = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TsWidth-1:0]   TsLast  = TsWidth'(WINDOW - 1);
    localparam logic [IDX_WIDTH-1:0] IdxLast = IDX_WIDTH'(NUM_OUTPUTS - 1);

    state_e                 state_q, state_d;
    logic [TsWidth-1:0]     ts_q, ts_d;
    logic [IDX_WIDTH-1:0]   scan_idx_q, scan_idx_d;
    logic [IDX_WIDTH-1:0]   max_idx_q, max_idx_d;
    logic [COUNT_WIDTH-1:0] max_cnt_q, max_cnt_d;
    logic [IDX_WIDTH-1:0]   win_idx_q, win_idx_d;
    logic [COUNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                   no_spikes_q, no_spikes_d;

    logic                   cnt_clr;
    logic [NUM_OUTPUTS-1:0] cnt_inc;
    logic [COUNT_WIDTH-1:0] counts [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0] scan_cnt;

    always_comb begin
        cnt_clr = (state_q == StIdle) && start;
        cnt_inc = '0;
        if ((state_q == StAccum) && spike_valid) begin
            cnt_inc = spike_in;
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        sat_counter #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_sat_counter (
            .clk_i  (clk),
            .rst_i  (rst),
            .clr_i  (cnt_clr),
            .inc_i  (cnt_inc[i]),
            .count_o(counts[i])
        );
    end

    assign scan_cnt = counts[scan_idx_q];

    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        scan_idx_d  = scan_idx_q;
        max_idx_d   = max_idx_q;
        max_cnt_d   = max_cnt_q;
        win_idx_d   = win_idx_q;
        win_cnt_d   = win_cnt_q;
        no_spikes_d = no_spikes_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    ts_d    = '0;
                end
            end
            StAccum: begin
                if (spike_valid) begin
                    ts_d = ts_q + TsWidth'(1);
                    if (ts_q == TsLast) begin
                        state_d    = StScan;
                        scan_idx_d = '0;
                    end
                end
            end
            StScan: begin
                // Index 0 seeds the running max; strict compare keeps the lowest index on ties.
                if ((scan_idx_q == '0) || (scan_cnt > max_cnt_q)) begin
                    max_cnt_d = scan_cnt;
                    max_idx_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
                if (scan_idx_q == IdxLast) begin
                    state_d     = StDone;
                    scan_idx_d  = '0;
                    win_idx_d   = max_idx_d;
                    win_cnt_d   = max_cnt_d;
                    no_spikes_d = (max_cnt_d == '0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ts_q        <= '0;
            scan_idx_q  <= '0;
            max_idx_q   <= '0;
            max_cnt_q   <= '0;
            win_idx_q   <= '0;
            win_cnt_q   <= '0;
            no_spikes_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            scan_idx_q  <= scan_idx_d;
            max_idx_q   <= max_idx_d;
            max_cnt_q   <= max_cnt_d;
            win_idx_q   <= win_idx_d;
            win_cnt_q   <= win_cnt_d;
            no_spikes_q <= no_spikes_d;
        end
    end

    assign busy         = (state_q == StAccum) || (state_q == StScan);
    assign result_valid = (state_q == StDone);
    assign winner_idx   = win_idx_q;
    assign winner_count = win_cnt_q;
    assign no_spikes    = no_spikes_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Bench for spike_count_classifier: three instances (WINDOW 10, WINDOW 4, 3-bit counters with
// WINDOW 12) checked every cycle against a window/argmax model plus directed literal checks.
module tb_spike_count_classifier;

    localparam int N = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start_v [3];
    logic         sv_v    [3];
    logic [N-1:0] spk_v   [3];
    logic         busy_v  [3];
    logic         rv_v    [3];
    logic         ns_v    [3];
    logic [6:0]   idx_v   [3];
    logic [7:0]   cnt0, cnt1;
    logic [2:0]   cnt2;

    int total = 0;
    int bad   = 0;

    spike_count_classifier #(.NUM_OUTPUTS(N), .COUNT_WIDTH(8), .WINDOW(10)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .spike_valid(sv_v[0]), .spike_in(spk_v[0]),
        .busy(busy_v[0]), .result_valid(rv_v[0]), .winner_idx(idx_v[0]),
        .winner_count(cnt0), .no_spikes(ns_v[0])
    );

    spike_count_classifier #(.NUM_OUTPUTS(N), .COUNT_WIDTH(8), .WINDOW(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .spike_valid(sv_v[1]), .spike_in(spk_v[1]),
        .busy(busy_v[1]), .result_valid(rv_v[1]), .winner_idx(idx_v[1]),
        .winner_count(cnt1), .no_spikes(ns_v[1])
    );

    spike_count_classifier #(.NUM_OUTPUTS(N), .COUNT_WIDTH(3), .WINDOW(12)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .spike_valid(sv_v[2]), .spike_in(spk_v[2]),
        .busy(busy_v[2]), .result_valid(rv_v[2]), .winner_idx(idx_v[2]),
        .winner_count(cnt2), .no_spikes(ns_v[2])
    );

    function automatic int win_of(input int u);
        return (u == 0) ? 10 : ((u == 1) ? 4 : 12);
    endfunction

    function automatic int cmax_of(input int u);
        return (u == 2) ? 7 : 255;
    endfunction

    function automatic int cnt_of(input int u);
        return (u == 0) ? int'(cnt0) : ((u == 1) ? int'(cnt1) : int'(cnt2));
    endfunction

    function automatic logic [N-1:0] bit_at(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Window model: phase 0 idle, 1 collecting, 2 waiting out the scan, 3 result cycle.
    int m_phase [3];
    int m_steps [3];
    int m_wait  [3];
    int m_cnt   [3][N];
    int e_busy  [3];
    int e_rv    [3];
    int e_idx   [3];
    int e_cnt   [3];
    int e_ns    [3];

    task automatic model_step();
        int best;
        if (rst) begin
            for (int u = 0; u < 3; u++) begin
                m_phase[u] = 0; m_steps[u] = 0; m_wait[u] = 0;
                e_busy[u] = 0; e_rv[u] = 0; e_idx[u] = 0; e_cnt[u] = 0; e_ns[u] = 0;
            end
        end else begin
            for (int u = 0; u < 3; u++) begin
                e_rv[u] = 0;
                case (m_phase[u])
                    0: if (start_v[u]) begin
                        for (int i = 0; i < N; i++) m_cnt[u][i] = 0;
                        m_steps[u] = 0;
                        m_phase[u] = 1;
                        e_busy[u]  = 1;
                    end
                    1: if (sv_v[u]) begin
                        for (int i = 0; i < N; i++)
                            if (spk_v[u][i] && m_cnt[u][i] < cmax_of(u)) m_cnt[u][i]++;
                        m_steps[u]++;
                        if (m_steps[u] == win_of(u)) begin
                            m_phase[u] = 2;
                            m_wait[u]  = N;
                        end
                    end
                    2: begin
                        m_wait[u]--;
                        if (m_wait[u] == 0) begin
                            best = 0;
                            for (int i = 1; i < N; i++)
                                if (m_cnt[u][i] > m_cnt[u][best]) best = i;
                            e_idx[u]   = best;
                            e_cnt[u]   = m_cnt[u][best];
                            e_ns[u]    = (m_cnt[u][best] == 0) ? 1 : 0;
                            e_rv[u]    = 1;
                            e_busy[u]  = 0;
                            m_phase[u] = 3;
                        end
                    end
                    default: m_phase[u] = 0;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d_busy", u), int'(busy_v[u]), e_busy[u]);
            chk($sformatf("u%0d_result_valid", u), int'(rv_v[u]), e_rv[u]);
            chk($sformatf("u%0d_winner_idx", u), int'(idx_v[u]), e_idx[u]);
            chk($sformatf("u%0d_winner_count", u), cnt_of(u), e_cnt[u]);
            chk($sformatf("u%0d_no_spikes", u), int'(ns_v[u]), e_ns[u]);
        end
    end

    task automatic do_start(input int u);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
    endtask

    task automatic step(input int u, input logic [N-1:0] s);
        sv_v[u]  = 1'b1;
        spk_v[u] = s;
        @(negedge clk);
        sv_v[u]  = 1'b0;
        spk_v[u] = '0;
    endtask

    // Called at the negedge just after the final strobe; lat counts clocks since that edge.
    task automatic wait_result(input int u, input bit noise, output int lat);
        lat = 1;
        while (!rv_v[u] && lat <= 200) begin
            if (noise) begin
                sv_v[u]  = ~sv_v[u];
                spk_v[u] = '1;
            end
            @(negedge clk);
            lat++;
        end
        sv_v[u]  = 1'b0;
        spk_v[u] = '0;
        if (!rv_v[u]) begin
            total++;
            bad++;
            $display("FAIL u%0d_timeout: result_valid got 0 expected 1 within 200 cycles", u);
        end
    endtask

    int lat;
    int pulses;

    initial begin
        for (int u = 0; u < 3; u++) begin
            start_v[u] = 1'b0;
            sv_v[u]    = 1'b0;
            spk_v[u]   = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy_v[0]), 0);
        chk("reset_idx", int'(idx_v[0]), 0);
        chk("reset_ns", int'(ns_v[0]), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single winner
        do_start(0);
        for (int k = 0; k < 10; k++) step(0, bit_at(37) | ((k < 3) ? bit_at(5) : '0));
        wait_result(0, 1'b0, lat);
        chk("single_latency", lat, 101);
        chk("single_idx", int'(idx_v[0]), 37);
        chk("single_cnt", int'(cnt0), 10);
        chk("single_ns", int'(ns_v[0]), 0);
        @(negedge clk);

        // Tie resolves to lowest index
        do_start(1);
        for (int k = 0; k < 4; k++) step(1, bit_at(12) | bit_at(80) | ((k < 3) ? bit_at(40) : '0));
        wait_result(1, 1'b0, lat);
        chk("tie_idx", int'(idx_v[1]), 12);
        chk("tie_cnt", int'(cnt1), 4);
        @(negedge clk);

        // Silence
        do_start(0);
        for (int k = 0; k < 10; k++) step(0, '0);
        wait_result(0, 1'b0, lat);
        chk("silence_idx", int'(idx_v[0]), 0);
        chk("silence_cnt", int'(cnt0), 0);
        chk("silence_ns", int'(ns_v[0]), 1);
        chk("silence_busy_in_done", int'(busy_v[0]), 0);
        @(negedge clk);

        // Saturation at 7 ties 99 with 50; lower index wins
        do_start(2);
        for (int k = 0; k < 12; k++)
            step(2, bit_at(99) | ((k < 7) ? bit_at(50) : '0) | ((k < 6) ? bit_at(3) : '0));
        wait_result(2, 1'b0, lat);
        chk("sat_idx", int'(idx_v[2]), 50);
        chk("sat_cnt", int'(cnt2), 7);
        @(negedge clk);

        // Gating: idle strobes and a start pulse mid-window, noise during scan
        do_start(0);
        for (int k = 0; k < 3; k++) step(0, bit_at(2) | ((k == 0) ? bit_at(9) : '0));
        for (int k = 0; k < 20; k++) begin
            spk_v[0]   = '1;
            start_v[0] = (k == 5);
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        spk_v[0]   = '0;
        chk("gate_busy_hold", int'(busy_v[0]), 1);
        for (int k = 0; k < 7; k++) step(0, bit_at(2));
        wait_result(0, 1'b1, lat);
        chk("gate_latency", lat, 101);
        chk("gate_idx", int'(idx_v[0]), 2);
        chk("gate_cnt", int'(cnt0), 10);
        @(negedge clk);

        // Reset while index 40 is being scanned
        do_start(0);
        for (int k = 0; k < 10; k++) step(0, bit_at(60));
        repeat (40) @(negedge clk);
        chk("rst_busy_before", int'(busy_v[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_rv", int'(rv_v[0]), 0);
        chk("rst_idx", int'(idx_v[0]), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_ns", int'(ns_v[0]), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        pulses = 0;
        repeat (120) begin
            @(negedge clk);
            if (rv_v[0]) pulses++;
        end
        chk("rst_no_pulse", pulses, 0);
        do_start(0);
        for (int k = 0; k < 10; k++) step(0, ((k % 3) == 0) ? bit_at(7) : '0);
        wait_result(0, 1'b0, lat);
        chk("after_rst_latency", lat, 101);
        chk("after_rst_idx", int'(idx_v[0]), 7);
        chk("after_rst_cnt", int'(cnt0), 4);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
